// File: rtl/bundle_kernel_pkg.sv
// Shared types and helpers for the majority-vote bundling kernel.
package bundle_kernel_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } BundleKernel_State_t;

  // Symmetric saturation bound of a signed counter: +/-(2^(w-1)-1).
  function automatic int unsigned sat_limit(input int unsigned count_width);
    return (32'd1 << (count_width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bundle_bit_counter.sv
// One signed saturating up/down vote counter with load, plus sign/zero flags.
module bundle_bit_counter
  import bundle_kernel_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_en,
  input  logic i_bit,
  output logic o_pos,
  output logic o_neg
);

  localparam logic signed [COUNT_WIDTH-1:0] CntMax      = COUNT_WIDTH'(sat_limit(COUNT_WIDTH));
  localparam logic signed [COUNT_WIDTH-1:0] CntMin      = -CntMax;
  localparam logic signed [COUNT_WIDTH-1:0] CntOne      = COUNT_WIDTH'(1);
  localparam logic signed [COUNT_WIDTH-1:0] CntMinusOne = '1;

  logic signed [COUNT_WIDTH-1:0] r_cnt;
  logic signed [COUNT_WIDTH-1:0] w_cnt_next;

  // Next count: load restarts at +/-1, otherwise step toward the vote and clamp at the limit.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_load) begin
      w_cnt_next = i_bit ? CntOne : CntMinusOne;
    end else if (i_en) begin
      if (i_bit) begin
        if (r_cnt != CntMax) w_cnt_next = r_cnt + CntOne;
      end else begin
        if (r_cnt != CntMin) w_cnt_next = r_cnt - CntOne;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_neg = r_cnt[COUNT_WIDTH-1];
  assign o_pos = !r_cnt[COUNT_WIDTH-1] && (r_cnt != '0);

endmodule

// File: rtl/bundle_kernel.sv
// Bitwise majority-vote bundling kernel: framed beat intake, per-bit vote counters,
// single-cycle resolve into a held result register.
module bundle_kernel
  import bundle_kernel_pkg::*;
#(
  parameter int unsigned              HV_DATA_WIDTH = 32,
  parameter int unsigned              COUNT_WIDTH   = 8,
  parameter logic [HV_DATA_WIDTH-1:0] TIE_PATTERN   = 32'hAAAAAAAA
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     k_valid,
  input  logic                     k_first,
  input  logic                     k_last,
  input  logic [HV_DATA_WIDTH-1:0] k_data_in,
  output logic                     k_ready,
  output logic [HV_DATA_WIDTH-1:0] k_data_out,
  output logic                     k_done,
  output logic                     protocol_err
);

  BundleKernel_State_t r_state;
  BundleKernel_State_t w_state_next;

  logic                     r_ready;
  logic                     r_done;
  logic                     r_err;
  logic [HV_DATA_WIDTH-1:0] r_data;

  logic                     w_accept;
  logic                     w_load;
  logic                     w_en;
  logic                     w_err;
  logic                     w_resolve;
  logic [HV_DATA_WIDTH-1:0] w_pos;
  logic [HV_DATA_WIDTH-1:0] w_neg;
  logic [HV_DATA_WIDTH-1:0] w_resolved;

  assign w_accept = k_valid & r_ready;

  // Next-state and counter control; a first beat always restarts the counters.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_en         = 1'b0;
    w_err        = 1'b0;
    w_resolve    = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (k_first) begin
            w_load       = 1'b1;
            w_state_next = k_last ? S_RESOLVE : S_ACCUM;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          if (k_first) begin
            // Previous bundle abandoned; restart from this beat.
            w_load = 1'b1;
            w_err  = 1'b1;
          end else begin
            w_en = 1'b1;
          end
          if (k_last) w_state_next = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        w_resolve    = 1'b1;
        w_state_next = S_DONE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output registers; ready is registered so it never depends on k_valid combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_ready <= (w_state_next != S_RESOLVE);
      r_err   <= w_err;
      if (w_resolve) begin
        r_done <= 1'b1;
        r_data <= w_resolved;
      end else if (w_load) begin
        r_done <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < HV_DATA_WIDTH; gi++) begin : g_bit
    bundle_bit_counter #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_load),
      .i_en    (w_en),
      .i_bit   (k_data_in[gi]),
      .o_pos   (w_pos[gi]),
      .o_neg   (w_neg[gi])
    );
    assign w_resolved[gi] = w_pos[gi] ? 1'b1 : (w_neg[gi] ? 1'b0 : TIE_PATTERN[gi]);
  end

  assign k_ready      = r_ready;
  assign k_done       = r_done;
  assign k_data_out   = r_data;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_bundle_kernel.sv
// Self-checking bench for bundle_kernel: vector table plus directed framing,
// saturation, reset and back-to-back sequences, with a result scoreboard.
module tb_bundle_kernel;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         k_valid;
  logic         k_first;
  logic         k_last;
  logic [W-1:0] k_data_in;
  logic         k_ready;
  logic [W-1:0] k_data_out;
  logic         k_done;
  logic         protocol_err;
  // Narrow-counter instance shares the inputs.
  logic         s_ready;
  logic [W-1:0] s_data_out;
  logic         s_done;
  logic         s_err;

  always #5 clk = ~clk;

  bundle_kernel #(
    .HV_DATA_WIDTH (W),
    .COUNT_WIDTH   (8),
    .TIE_PATTERN   (32'hAAAAAAAA)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .k_valid      (k_valid),
    .k_first      (k_first),
    .k_last       (k_last),
    .k_data_in    (k_data_in),
    .k_ready      (k_ready),
    .k_data_out   (k_data_out),
    .k_done       (k_done),
    .protocol_err (protocol_err)
  );

  bundle_kernel #(
    .HV_DATA_WIDTH (W),
    .COUNT_WIDTH   (4),
    .TIE_PATTERN   (32'hAAAAAAAA)
  ) dut4 (
    .clk          (clk),
    .reset_n      (reset_n),
    .k_valid      (k_valid),
    .k_first      (k_first),
    .k_last       (k_last),
    .k_data_in    (k_data_in),
    .k_ready      (s_ready),
    .k_data_out   (s_data_out),
    .k_done       (s_done),
    .protocol_err (s_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int unsigned     n;
    logic [2:0][31:0] w;
    logic [31:0]     exp;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input int unsigned n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] e);
    vec_t v;
    v.n    = n;
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.exp  = e;
    return v;
  endfunction

  // One beat: present at negedge, wait (bounded) for ready, accepted at next posedge.
  task automatic drive_beat(input logic first, input logic last, input logic [31:0] data,
                            input logic [31:0] exp);
    int waits = 0;
    @(negedge clk);
    k_valid   = 1'b1;
    k_first   = first;
    k_last    = last;
    k_data_in = data;
    while (!k_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (!k_ready) check("ready_timeout", {31'd0, k_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (last) begin
      exp_t e;
      e.data = exp;
      e.cyc  = cyc;
      sb.push_back(e);
    end
    k_valid = 1'b0;
    k_first = 1'b0;
    k_last  = 1'b0;
  endtask

  task automatic run_bundle(input vec_t v);
    for (int b = 0; b < int'(v.n); b++) begin
      drive_beat(b == 0, b == int'(v.n) - 1, v.w[b], v.exp);
      // The accepting edge of a first beat clears any pending result.
      if (b == 0 && v.n > 1) check("done_clear", {31'd0, k_done}, 32'd0);
    end
  endtask

  // Result monitor: each rising k_done pops the scoreboard.
  logic prev_done = 1'b0;
  int   ready_low = 0;
  always @(negedge clk) begin
    if (reset_n && k_done && !prev_done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        check("result", k_data_out, sb[0].data);
        check("latency_edges", 32'(cyc - sb[0].cyc), 32'd1);
        void'(sb.pop_front());
      end
    end
    prev_done <= k_done;
    if (!k_ready) begin
      ready_low <= ready_low + 1;
    end else begin
      if (ready_low != 0) check("ready_low_cycles", 32'(ready_low), 32'd1);
      ready_low <= 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = mk(2, 32'h0000FFFF, 32'h00FF00FF, 32'h0,        32'h00AAAAFF);
    vecs[1] = mk(3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF00FF00);
    vecs[2] = mk(1, 32'h12345678, 32'h0,        32'h0,        32'h12345678);
    vecs[3] = mk(2, 32'hFFFF0000, 32'h0000FFFF, 32'h0,        32'hAAAAAAAA);
    vecs[4] = mk(3, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000);
    vecs[5] = mk(3, 32'hC3C3C3C3, 32'h0F0F0F0F, 32'h3C3C3C3C, 32'h0F0F0F0F);

    reset_n   = 1'b0;
    k_valid   = 1'b0;
    k_first   = 1'b0;
    k_last    = 1'b0;
    k_data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, k_ready}, 32'd1);
    check("rst_done", {31'd0, k_done}, 32'd0);
    check("rst_data", k_data_out, 32'd0);
    check("rst_err", {31'd0, protocol_err}, 32'd0);
    check("rst4_ready", {31'd0, s_ready}, 32'd1);
    check("rst4_err", {31'd0, s_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Beat without first in idle: dropped with a one-cycle error pulse.
    drive_beat(1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    check("idle_err_pulse", {31'd0, protocol_err}, 32'd1);
    @(posedge clk);
    #1;
    check("idle_err_clear", {31'd0, protocol_err}, 32'd0);
    check("idle_ready", {31'd0, k_ready}, 32'd1);
    check("idle_done", {31'd0, k_done}, 32'd0);

    // Table vectors, issued back-to-back.
    foreach (vecs[i]) run_bundle(vecs[i]);

    // First beat in accumulate abandons the earlier bundle.
    drive_beat(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0);
    drive_beat(1'b1, 1'b0, 32'h0000FFFF, 32'h0);
    check("restart_err", {31'd0, protocol_err}, 32'd1);
    drive_beat(1'b0, 1'b1, 32'h00FF00FF, 32'h00AAAAFF);

    // 10 ones then 9 zeros: wide counter keeps majority 1, 4-bit counter saturates at 7.
    for (int b = 0; b < 19; b++) begin
      drive_beat(b == 0, b == 18, (b < 10) ? 32'hFFFFFFFF : 32'h00000000, 32'hFFFFFFFF);
    end
    @(negedge clk);
    @(negedge clk);
    check("sat4_done", {31'd0, s_done}, 32'd1);
    check("sat4_data", s_data_out, 32'h00000000);

    // Reset mid-accumulate: outputs return to reset values at once, no result.
    drive_beat(1'b1, 1'b0, 32'h55555555, 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, k_ready}, 32'd1);
    check("arst_done", {31'd0, k_done}, 32'd0);
    check("arst_data", k_data_out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_no_done", {31'd0, k_done}, 32'd0);

    // Recovery after reset.
    run_bundle(vecs[1]);
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
